// File: rtl/clk_gate_pkg.sv
// Shared constants for the clock-enable sequencer: state encoding and
// default wake/drain timing, reused by the RTL and the bench.
package clk_gate_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int WAKE_CYCLES_DEF  = 4;
    localparam int DRAIN_CYCLES_DEF = 8;
    localparam int CNT_W_DEF        = 8;
    localparam int EVT_W_DEF        = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count events, stopping at all-ones so the value never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (srst) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && !(&cnt_r)) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Registered clock-enable sequencer for a gated-clock cell CE input.
// OFF -> WAKE (settle) -> ON (ack) -> DRAIN (wait for not-busy) -> OFF.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES  = WAKE_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int EVT_W        = EVT_W_DEF
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             req,
    input  logic             force_on,
    input  logic             busy,
    output logic             clken,
    output logic             ack,
    output logic [1:0]       state_o,
    output logic [EVT_W-1:0] gate_evt
);

    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             want_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             clken_r;
    logic             ack_r;
    logic             evt_inc_s;

    assign want_s = req | force_on;

    // Next-state and down-counter decode; drain re-request wins over expiry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        evt_inc_s   = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (want_s) begin
                    state_nxt_s = ST_WAKE;
                    cnt_nxt_s   = WAKE_LOAD;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_WAKE: begin
                // Not abortable: always proceeds to ON once settled.
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_ON;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_ON: begin
                if (!want_s) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = DRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_DRAIN: begin
                if (want_s) begin
                    // Clock never stopped, so no settle period is needed.
                    state_nxt_s = ST_ON;
                end else if (busy) begin
                    cnt_nxt_s = DRAIN_LOAD;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    state_nxt_s = ST_OFF;
                    evt_inc_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and outputs are all flops so clken cannot glitch.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            cnt_r   <= CNT_ZERO;
            clken_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            clken_r <= (state_nxt_s != ST_OFF);
            ack_r   <= (state_nxt_s == ST_ON);
        end
    end

    sat_counter #(
        .W (EVT_W)
    ) u_evt_cnt (
        .clk   (clkin),
        .rst_n (rst_n),
        .srst  (1'b0),
        .inc   (evt_inc_s),
        .cnt   (gate_evt)
    );

    assign clken   = clken_r;
    assign ack     = ack_r;
    assign state_o = state_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: vector table plus multi-cycle sequences.
module tb_clk_gate_ctrl;
    import clk_gate_pkg::*;

    logic        clkin = 1'b0;
    logic        rst_n, req, force_on, busy;
    logic        clken, ack;
    logic [1:0]  state_o;
    logic [15:0] gate_evt;

    // Small-parameter instance used only to reach saturation quickly.
    logic        req2, force_on2, busy2;
    logic        clken2, ack2;
    logic [1:0]  state2;
    logic [2:0]  evt2;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        req;
        logic        force_on;
        logic        busy;
        logic        clken;
        logic        ack;
        logic [1:0]  st;
        logic [15:0] evt;
    } vec_t;

    vec_t vecs[19];

    always #5 clkin = ~clkin;

    clk_gate_ctrl dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .req      (req),
        .force_on (force_on),
        .busy     (busy),
        .clken    (clken),
        .ack      (ack),
        .state_o  (state_o),
        .gate_evt (gate_evt)
    );

    clk_gate_ctrl #(
        .WAKE_CYCLES  (1),
        .DRAIN_CYCLES (1),
        .CNT_W        (4),
        .EVT_W        (3)
    ) dut_sat (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .req      (req2),
        .force_on (force_on2),
        .busy     (busy2),
        .clken    (clken2),
        .ack      (ack2),
        .state_o  (state2),
        .gate_evt (evt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic [1:0] pulse_state(input int k);
        if (k < WAKE_CYCLES_DEF) return ST_WAKE;
        else if (k == WAKE_CYCLES_DEF) return ST_ON;
        else if (k <= WAKE_CYCLES_DEF + DRAIN_CYCLES_DEF) return ST_DRAIN;
        else return ST_OFF;
    endfunction

    initial begin
        logic       clk_hi;
        int         n;
        int         ack_cnt;
        logic [1:0] es;

        // Vector table: inputs applied before an edge, outputs expected after it.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF, 16'd0};
        for (int i = 1; i <= 4; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_WAKE, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ST_ON, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ST_ON, 16'd0};
        for (int i = 7; i <= 14; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_DRAIN, 16'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF, 16'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST_OFF, 16'd1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ST_WAKE, 16'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ST_WAKE, 16'd1};

        rst_n = 1'b0; req = 1'b0; force_on = 1'b0; busy = 1'b0;
        req2 = 1'b0; force_on2 = 1'b0; busy2 = 1'b0;
        #12;
        check("reset clken", {31'd0, clken}, 32'd0);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset state", {30'd0, state_o}, 32'd0);
        check("reset evt", {16'd0, gate_evt}, 32'd0);
        rst_n = 1'b1;
        repeat (9) tick();

        foreach (vecs[i]) begin
            req = vecs[i].req; force_on = vecs[i].force_on; busy = vecs[i].busy;
            tick();
            check($sformatf("vec%0d clken", i), {31'd0, clken}, {31'd0, vecs[i].clken});
            check($sformatf("vec%0d ack", i), {31'd0, ack}, {31'd0, vecs[i].ack});
            check($sformatf("vec%0d state", i), {30'd0, state_o}, {30'd0, vecs[i].st});
            check($sformatf("vec%0d evt", i), {16'd0, gate_evt}, {16'd0, vecs[i].evt});
        end

        // Asynchronous reset in WAKE, checked before any further edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst wake clken", {31'd0, clken}, 32'd0);
        check("rst wake state", {30'd0, state_o}, 32'd0);
        check("rst wake evt", {16'd0, gate_evt}, 32'd0);
        force_on = 1'b0; busy = 1'b0;
        tick();
        #2 rst_n = 1'b1;

        // Drain held off by busy for 20 cycles after the drop.
        req = 1'b1; tick(); repeat (4) tick();
        check("busy pre on", {30'd0, state_o}, {30'd0, ST_ON});
        req = 1'b0; busy = 1'b1; tick();
        check("busy drop state", {30'd0, state_o}, {30'd0, ST_DRAIN});
        check("busy drop ack", {31'd0, ack}, 32'd0);
        clk_hi = 1'b1;
        repeat (20) begin tick(); clk_hi &= clken; end
        busy = 1'b0;
        n = 0;
        while (state_o != ST_OFF && n < 100) begin tick(); n++; end
        check("busy hold clken", {31'd0, clk_hi}, 32'd1);
        check("busy drain len", n, 32'd8);
        check("busy clken off", {31'd0, clken}, 32'd0);
        check("busy evt", {16'd0, gate_evt}, 32'd1);

        // Re-request three cycles into DRAIN returns straight to ON.
        req = 1'b1; tick(); repeat (4) tick();
        req = 1'b0; tick();
        clk_hi = clken;
        tick(); clk_hi &= clken;
        tick(); clk_hi &= clken;
        check("rereq drain state", {30'd0, state_o}, {30'd0, ST_DRAIN});
        req = 1'b1; tick(); clk_hi &= clken;
        check("rereq state", {30'd0, state_o}, {30'd0, ST_ON});
        check("rereq ack", {31'd0, ack}, 32'd1);
        check("rereq clken held", {31'd0, clk_hi}, 32'd1);
        check("rereq evt", {16'd0, gate_evt}, 32'd1);
        req = 1'b0;
        repeat (9) tick();
        check("rereq off evt", {16'd0, gate_evt}, 32'd2);

        // One-cycle pulse from OFF: pass 0 uses req, pass 1 uses force_on.
        for (int p = 0; p < 2; p++) begin
            ack_cnt = 0;
            if (p == 0) req = 1'b1; else force_on = 1'b1;
            for (int k = 0; k < 16; k++) begin
                tick();
                req = 1'b0; force_on = 1'b0;
                es = pulse_state(k);
                if (ack) ack_cnt++;
                check($sformatf("pulse%0d k%0d state", p, k), {30'd0, state_o}, {30'd0, es});
                check($sformatf("pulse%0d k%0d clken", p, k), {31'd0, clken}, {31'd0, (es != ST_OFF)});
            end
            check($sformatf("pulse%0d ack cycles", p), ack_cnt, 32'd1);
            check($sformatf("pulse%0d evt", p), {16'd0, gate_evt}, 32'd3 + p);
        end

        // Asynchronous reset in DRAIN.
        req = 1'b1; tick(); repeat (4) tick();
        req = 1'b0; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst drain clken", {31'd0, clken}, 32'd0);
        check("rst drain ack", {31'd0, ack}, 32'd0);
        check("rst drain state", {30'd0, state_o}, 32'd0);
        check("rst drain evt", {16'd0, gate_evt}, 32'd0);
        tick();
        #2 rst_n = 1'b1;

        // Event counter saturation on the small instance.
        for (int ev = 1; ev <= 10; ev++) begin
            req2 = 1'b1; tick();
            if (ev == 1) check("sat wake state", {30'd0, state2}, {30'd0, ST_WAKE});
            req2 = 1'b0; repeat (4) tick();
            check($sformatf("sat evt%0d", ev), {29'd0, evt2}, (ev > 7) ? 32'd7 : ev);
        end
        check("sat idle clken", {30'd0, clken2, ack2}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
